// File: rtl/pipe_stage_skid_pkg.sv
// Shared widths, control-bit positions and occupancy states for the
// decode-to-execute skid stage.
package pipe_stage_skid_pkg;

  localparam int CTRL_W_DEF   = 8;
  localparam int DATA_W_DEF   = 140;

  localparam int WB_EN_BIT    = 0;
  localparam int MEM_R_EN_BIT = 1;
  localparam int MEM_W_EN_BIT = 2;
  localparam int B_BIT        = 3;
  localparam int EXE_CMD_LSB  = 4;
  localparam int EXE_CMD_MSB  = 7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // True when the control word would cause a write-back, memory or branch effect.
  function automatic logic has_side_effect(input logic [CTRL_W_DEF-1:0] ctrl);
    return ctrl[WB_EN_BIT] | ctrl[MEM_R_EN_BIT] | ctrl[MEM_W_EN_BIT] | ctrl[B_BIT];
  endfunction

  function automatic logic [3:0] exe_cmd(input logic [CTRL_W_DEF-1:0] ctrl);
    return ctrl[EXE_CMD_MSB:EXE_CMD_LSB];
  endfunction

endpackage

// File: rtl/pipe_stage_skid_entry_reg.sv
// One pipeline entry (valid + control + payload) with async reset and a
// synchronous clear that wins over load.
module pipe_entry_reg #(
  parameter int CTRL_W   = 8,
  parameter int DATA_W   = 140,
  parameter int CLR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (CLR_DATA != 0) data_d = '0;
    end else if (load) begin
      // An invalid entry never carries control bits, so bubbles are inert.
      valid_d = d_valid;
      ctrl_d  = d_valid ? d_ctrl : '0;
      data_d  = d_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid stage: main register drives the outputs, skid register
// catches the entry accepted while downstream stalls.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W            = DATA_W_DEF,
  parameter int CTRL_W            = CTRL_W_DEF,
  parameter int CLR_DATA_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic              main_load, main_d_valid;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;
  logic              skid_load, skid_d_valid;
  logic [CTRL_W-1:0] skid_d_ctrl;
  logic [DATA_W-1:0] skid_d_data;

  state_e state;
  logic   accept, pop;

  // Valid-ready: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready depends only on the skid flop, never on out_ready.
  assign accept = in_valid & ~skid_valid;
  assign pop    = main_valid & out_ready;

  always_comb begin
    unique case ({main_valid, skid_valid})
      2'b10:   state = ST_ONE;
      2'b11:   state = ST_FULL;
      default: state = ST_EMPTY;
    endcase
  end

  always_comb begin
    main_load    = 1'b0;
    main_d_valid = 1'b0;
    main_d_ctrl  = in_ctrl;
    main_d_data  = in_data;
    skid_load    = 1'b0;
    skid_d_valid = 1'b0;
    skid_d_ctrl  = in_ctrl;
    skid_d_data  = in_data;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_load    = 1'b1;
          main_d_valid = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_load    = 1'b1;
          main_d_valid = 1'b1;
        end else if (accept) begin
          skid_load    = 1'b1;
          skid_d_valid = 1'b1;
        end else if (pop) begin
          main_load    = 1'b1;
          main_d_data  = main_data;
        end
      end
      ST_FULL: begin
        if (pop) begin
          main_load    = 1'b1;
          main_d_valid = 1'b1;
          main_d_ctrl  = skid_ctrl;
          main_d_data  = skid_data;
          skid_load    = 1'b1;
          skid_d_data  = skid_data;
        end
      end
      default: ;
    endcase
  end

  pipe_entry_reg #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .CLR_DATA(CLR_DATA_ON_FLUSH)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .load   (main_load),
    .d_valid(main_d_valid),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .valid  (main_valid),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  pipe_entry_reg #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .CLR_DATA(CLR_DATA_ON_FLUSH)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .load   (skid_load),
    .d_valid(skid_d_valid),
    .d_ctrl (skid_d_ctrl),
    .d_data (skid_d_data),
    .valid  (skid_valid),
    .ctrl   (skid_ctrl),
    .data   (skid_data)
  );

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus a randomized run checked
// every cycle against a two-slot queue model.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  localparam int CW = 8;
  localparam int DW = 140;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;

  ent_t m_q[$];
  logic m_zero;

  pipe_stage_skid dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  // reference model: at most two held entries, oldest at the front
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_zero = 1'b1;
    end else if (flush) begin
      m_q.delete();
      m_zero = 1'b1;
    end else begin
      automatic bit acc = in_valid && (m_q.size() < 2);
      automatic bit pp  = (m_q.size() > 0) && out_ready;
      if (pp) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back('{c: in_ctrl, d: in_data});
        m_zero = 1'b0;
      end
    end
  end

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      automatic int sz = m_q.size();
      check("m_out_valid", 256'(out_valid), 256'(sz > 0));
      check("m_occupancy", 256'(occupancy), 256'(sz));
      check("m_in_ready",  256'(in_ready),  256'(sz < 2));
      if (sz > 0) begin
        check("m_out_ctrl", 256'(out_ctrl), 256'(m_q[0].c));
        check("m_out_data", 256'(out_data), 256'(m_q[0].d));
      end else begin
        check("m_bubble_ctrl", 256'(out_ctrl), 256'(0));
        if (m_zero) check("m_zero_data", 256'(out_data), 256'(0));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #22 rst = 1'b0;
    #1;
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out_ctrl",  256'(out_ctrl),  256'(0));
    check("rst_out_data",  256'(out_data),  256'(0));
    check("rst_occupancy", 256'(occupancy), 256'(0));
    check("rst_in_ready",  256'(in_ready),  256'(1));
    chk_en = 1'b1;

    // first entry
    drive(1'b1, 8'h1D, 140'h40);
    out_ready = 1'b1;
    tick();
    drive(1'b0, '0, '0);
    check("first_valid", 256'(out_valid), 256'(1));
    check("first_ctrl",  256'(out_ctrl),  256'(8'h1D));
    check("first_data",  256'(out_data),  256'(140'h40));
    check("first_occ",   256'(occupancy), 256'(1));
    check("first_cmd",   256'(exe_cmd(out_ctrl)), 256'(4'h1));
    check("first_side",  256'(has_side_effect(out_ctrl)), 256'(1));
    tick();
    check("first_drain", 256'(out_valid), 256'(0));

    // A, B, C with downstream stalled
    out_ready = 1'b0;
    drive(1'b1, 8'hA1, 140'hAAAA);
    tick();
    drive(1'b1, 8'hB2, 140'hBBBB);
    tick();
    drive(1'b1, 8'hC3, 140'hCCCC);
    tick();
    check("full_occ",   256'(occupancy), 256'(2));
    check("full_ready", 256'(in_ready),  256'(0));
    check("full_head",  256'(out_data),  256'(140'hAAAA));
    tick();
    check("full_hold_occ", 256'(occupancy), 256'(2));
    out_ready = 1'b1;
    tick();
    check("drain_b", 256'(out_data),  256'(140'hBBBB));
    check("drain_b_ready", 256'(in_ready), 256'(1));
    tick();
    check("drain_c", 256'(out_data),  256'(140'hCCCC));
    check("drain_c_ctrl", 256'(out_ctrl), 256'(8'hC3));
    drive(1'b0, '0, '0);
    tick();
    check("drain_empty", 256'(occupancy), 256'(0));

    // flush from FULL with an entry offered in the flush cycle
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 140'h111);
    tick();
    drive(1'b1, 8'h22, 140'h222);
    tick();
    check("pre_flush_occ", 256'(occupancy), 256'(2));
    flush = 1'b1;
    drive(1'b1, 8'h33, 140'h333);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("flush_occ",   256'(occupancy), 256'(0));
    check("flush_valid", 256'(out_valid), 256'(0));
    check("flush_ctrl",  256'(out_ctrl),  256'(0));
    check("flush_data",  256'(out_data),  256'(0));
    check("flush_ready", 256'(in_ready),  256'(1));
    out_ready = 1'b1;
    tick();
    tick();
    check("flush_discard", 256'(out_valid), 256'(0));

    // 100 back-to-back entries
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 8'(i), 140'(32'hA000 + i));
      tick();
      check("b2b_valid", 256'(out_valid), 256'(1));
      check("b2b_data",  256'(out_data),  256'(32'hA000 + i));
      check("b2b_ready", 256'(in_ready),  256'(1));
    end
    drive(1'b0, '0, '0);
    tick();

    // asynchronous reset mid-cycle while holding one entry
    out_ready = 1'b0;
    drive(1'b1, 8'h5E, 140'h5E5E);
    tick();
    drive(1'b0, '0, '0);
    check("pre_rst_occ", 256'(occupancy), 256'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 256'(out_valid), 256'(0));
    check("arst_ctrl",  256'(out_ctrl),  256'(0));
    check("arst_data",  256'(out_data),  256'(0));
    check("arst_occ",   256'(occupancy), 256'(0));
    check("arst_ready", 256'(in_ready),  256'(1));
    #3 rst = 1'b0;
    tick();
    drive(1'b1, 8'h6F, 140'h6F6F);
    tick();
    drive(1'b0, '0, '0);
    check("post_rst_data", 256'(out_data),  256'(140'h6F6F));
    check("post_rst_occ",  256'(occupancy), 256'(1));

    // randomized traffic, occasional flush
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom),
            140'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
